// File: rtl/cpu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// cpu_fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   ADDR_W / INSTR_W : PC and instruction widths
//   PC_STEP          : sequential PC increment (word-addressed ROM)
//   OPC_MSB/OPC_LSB  : opcode field position inside an instruction
//   HALT_OPCODE      : opcode that stops fetch
//   fetch_state_t    : fetch state machine encoding
//   ifid_t           : IF/ID pipeline register contents
// ---------------------------------------------------------------------------
package cpu_fetch_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;

    localparam logic [ADDR_W-1:0]        PC_STEP     = 16'd1;
    localparam logic [OPC_MSB-OPC_LSB:0] HALT_OPCODE = 4'hF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic               valid;
    } ifid_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// ---------------------------------------------------------------------------
// fetch_perf_counters
// Two free-running 32-bit event counters for the fetch stage. Both wrap
// silently and clear on reset.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   load_valid    : IF/ID is being loaded with a valid instruction this edge
//   bubble        : IF/ID is loaded empty or held by a stall (not halted)
//   perf_fetched  : count of load_valid edges
//   perf_bubbles  : count of bubble edges
// ---------------------------------------------------------------------------
module fetch_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic        bubble,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (load_valid) perf_fetched <= perf_fetched + 32'd1;
            if (bubble)     perf_bubbles <= perf_bubbles + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage around an external PC register and a synchronous
// (1-cycle latency) instruction ROM. Computes the next PC, tracks which
// address the ROM is currently answering for, and loads the IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined;
// otherwise perf_fetched/perf_bubbles are tied to 0.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   pc_in / pc_next              : PC register address_out / address_in
//   imem_addr / imem_rdata       : ROM address and its next-cycle data
//   stall                        : hold PC and IF/ID
//   branch_taken/branch_target   : redirect from execute (beats stall)
//   ifid_instr/ifid_pc/ifid_valid: IF/ID register to decode
//   halted                       : fetch stopped by a HALT instruction
//   perf_fetched/perf_bubbles    : optional event counters
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [ADDR_W-1:0]  pc_next,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic               ifid_valid,
    output logic               halted,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles
);

    fetch_state_t       state, state_next;
    ifid_t              ifid_q, ifid_d;
    logic [ADDR_W-1:0]  fetch_pc_q;
    logic               fetch_valid_q;
    logic [INSTR_W-1:0] held_rdata_q;
    logic               hold_active_q;
    logic [INSTR_W-1:0] fetch_instr;
    logic               halt_detect;
    logic               halting;
    logic               ifid_hold;

    assign imem_addr = pc_in;

    // A HALT sitting in IF/ID stops fetch unless a branch is flushing it.
    assign halt_detect = (state == RUN) && ifid_q.valid &&
                         is_halt(ifid_q.instr) && !branch_taken;
    assign halting     = (state == HALTED) || halt_detect;
    assign ifid_hold   = stall && !branch_taken;

    // The ROM keeps answering for pc_in while stalled, which moves one
    // address ahead of fetch_pc_q; the word that matches fetch_pc_q is
    // captured on the first stalled edge and replayed on release.
    assign fetch_instr = hold_active_q ? held_rdata_q : imem_rdata;

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // HALTED is sticky until reset.
    always_comb begin
        state_next = state;
        if (state == RUN && halt_detect) state_next = HALTED;
    end

    always_comb begin
        if (reset)                pc_next = '0;
        else if (state == HALTED) pc_next = pc_in;
        else if (branch_taken)    pc_next = branch_target;
        else if (stall)           pc_next = pc_in;
        else                      pc_next = pc_in + PC_STEP;

        ifid_d = ifid_q;
        if (branch_taken) begin
            ifid_d.valid = 1'b0;
        end else if (!stall) begin
            ifid_d.instr = fetch_instr;
            ifid_d.pc    = fetch_pc_q;
            ifid_d.valid = fetch_valid_q && !halting;
        end
    end

    // fetch_valid_q holds across a stall so it stays paired with the held
    // fetch_pc_q and captured ROM word.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_q        <= '0;
            fetch_pc_q    <= '0;
            fetch_valid_q <= 1'b0;
            held_rdata_q  <= '0;
            hold_active_q <= 1'b0;
        end else begin
            ifid_q <= ifid_d;
            if (!ifid_hold) fetch_pc_q <= pc_in;
            if (branch_taken || state == HALTED) fetch_valid_q <= 1'b0;
            else if (!stall)                     fetch_valid_q <= 1'b1;
            if (ifid_hold) begin
                if (!hold_active_q) held_rdata_q <= imem_rdata;
                hold_active_q <= 1'b1;
            end else begin
                hold_active_q <= 1'b0;
            end
        end
    end

    assign ifid_instr = ifid_q.instr;
    assign ifid_pc    = ifid_q.pc;
    assign ifid_valid = ifid_q.valid;
    assign halted     = (state == HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic load_valid;
    logic bubble;

    // Every running edge either loads a real instruction or is a bubble.
    assign load_valid = !reset && !ifid_hold && ifid_d.valid;
    assign bubble     = !reset && (state == RUN) && !load_valid;

    fetch_perf_counters u_perf (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .bubble       (bubble),
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles)
    );
`else
    assign perf_fetched = '0;
    assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. Models the external PC register and a
// synchronous ROM where ROM[a] = a, except address 7 holds a HALT when
// halt_en is set. Honours FETCH_PERF_CNT_EN for the counter checks.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    import cpu_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_in, pc_next, imem_addr, branch_target, ifid_pc;
    logic [31:0] imem_rdata, ifid_instr, perf_fetched, perf_bubbles;
    logic        stall, branch_taken, ifid_valid, halted;

    logic [15:0] pc_reg;
    logic [15:0] pc_force;
    logic        force_en = 1'b0;
    logic        halt_en  = 1'b0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic [15:0] tgt;
        logic [15:0] pc;
        logic [15:0] exp_next;
    } vec_t;

    vec_t vecs[9];

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pc_in         (pc_in),
        .pc_next       (pc_next),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_valid    (ifid_valid),
        .halted        (halted),
        .perf_fetched  (perf_fetched),
        .perf_bubbles  (perf_bubbles)
    );

    always #5 clk = ~clk;

    assign pc_in = force_en ? pc_force : pc_reg;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return (halt_en && a == 16'd7) ? 32'hF000_0007 : {16'h0000, a};
    endfunction

    // External PC register and synchronous ROM.
    always @(posedge clk) begin
        pc_reg     <= pc_next;
        imem_rdata <= rom_word(imem_addr);
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset         = v.rst;
        stall         = v.stl;
        branch_taken  = v.br;
        branch_target = v.tgt;
        pc_force      = v.pc;
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        repeat (2) step();
    endtask

    task automatic wait_for_ifid(input logic [15:0] pc);
        int n = 0;
        while (!(ifid_valid && ifid_pc == pc) && n < 40) begin
            step();
            n++;
        end
        check_output($sformatf("reach ifid_pc=%h", pc), {31'b0, ifid_valid && ifid_pc == pc}, 32'd1);
    endtask

    task automatic wait_for_pc(input logic [15:0] pc);
        int n = 0;
        while (pc_reg != pc && n < 40) begin
            step();
            n++;
        end
        check_output($sformatf("reach pc_in=%h", pc), {16'h0, pc_reg}, {16'h0, pc});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] fet0, bub0;

        //       rst   stall br    target    pc_in     expected pc_next
        vecs = '{
            '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000},
            '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001},
            '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h1235},
            '{1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000},
            '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0042, 16'h0042},
            '{1'b0, 1'b0, 1'b1, 16'h0040, 16'h0010, 16'h0040},
            '{1'b0, 1'b1, 1'b1, 16'h0100, 16'h0020, 16'h0100},
            '{1'b1, 1'b0, 1'b1, 16'h0077, 16'h0033, 16'h0000},
            '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0099, 16'h0000}
        };

        // Reset state.
        do_reset();
        check_output("reset ifid_valid", {31'b0, ifid_valid}, 32'd0);
        check_output("reset ifid_pc", {16'h0, ifid_pc}, 32'd0);
        check_output("reset ifid_instr", ifid_instr, 32'd0);
        check_output("reset halted", {31'b0, halted}, 32'd0);
        check_output("reset pc_next", {16'h0, pc_next}, 32'd0);
        check_output("reset perf_fetched", perf_fetched, 32'd0);
        check_output("reset perf_bubbles", perf_bubbles, 32'd0);

        // Table-driven next-PC priority (state stays RUN, no HALT in ROM).
        force_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d pc_next", i), {16'h0, pc_next}, {16'h0, vecs[i].exp_next});
            check_output($sformatf("vec%0d imem_addr", i), {16'h0, imem_addr}, {16'h0, vecs[i].pc});
        end
        force_en = 1'b0;

        // Free run from reset.
        do_reset();
        reset = 1'b0;
        #1;
        check_output("run pc_next c0", {16'h0, pc_next}, 32'd1);
        step();
        check_output("run ifid_valid e1", {31'b0, ifid_valid}, 32'd0);
        check_output("run pc_next e1", {16'h0, pc_next}, 32'd2);
        step();
        check_output("run ifid_valid e2", {31'b0, ifid_valid}, 32'd1);
        check_output("run ifid_pc e2", {16'h0, ifid_pc}, 32'd0);
        check_output("run ifid_instr e2", ifid_instr, 32'd0);
        check_output("run pc_next e2", {16'h0, pc_next}, 32'd3);
        step();
        check_output("run ifid_pc e3", {16'h0, ifid_pc}, 32'd1);
        check_output("run ifid_instr e3", ifid_instr, 32'd1);

        // Stall for three edges with ifid_pc=5.
        wait_for_ifid(16'd5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output($sformatf("stall%0d ifid_pc", i), {16'h0, ifid_pc}, 32'd5);
            check_output($sformatf("stall%0d ifid_instr", i), ifid_instr, 32'd5);
            check_output($sformatf("stall%0d pc_next", i), {16'h0, pc_next}, 32'd7);
        end
        stall = 1'b0;
        step();
        check_output("unstall ifid_pc", {16'h0, ifid_pc}, 32'd6);
        check_output("unstall ifid_instr", ifid_instr, 32'd6);
        check_output("unstall ifid_valid", {31'b0, ifid_valid}, 32'd1);
        step();
        check_output("unstall+1 ifid_pc", {16'h0, ifid_pc}, 32'd7);
        check_output("unstall+1 ifid_instr", ifid_instr, 32'd7);

        // Branch redirect: two bubbles, then the target.
        wait_for_pc(16'h0010);
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        #1;
        check_output("branch pc_next", {16'h0, pc_next}, 32'h40);
        fet0 = perf_fetched;
        bub0 = perf_bubbles;
        step();
        branch_taken = 1'b0;
        #1;
        check_output("branch bubble1", {31'b0, ifid_valid}, 32'd0);
        step();
        check_output("branch bubble2", {31'b0, ifid_valid}, 32'd0);
        step();
        check_output("branch ifid_valid", {31'b0, ifid_valid}, 32'd1);
        check_output("branch ifid_pc", {16'h0, ifid_pc}, 32'h40);
        check_output("branch ifid_instr", ifid_instr, 32'h40);
`ifdef FETCH_PERF_CNT_EN
        check_output("perf_bubbles delta", perf_bubbles - bub0, 32'd2);
        check_output("perf_fetched delta", perf_fetched - fet0, 32'd1);
`else
        check_output("perf_bubbles tied", perf_bubbles, 32'd0);
        check_output("perf_fetched tied", perf_fetched, 32'd0);
`endif

        // Stall and branch together: branch wins.
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 16'h0100;
        #1;
        check_output("stall+br pc_next", {16'h0, pc_next}, 32'h100);
        step();
        stall        = 1'b0;
        branch_taken = 1'b0;
        #1;
        check_output("stall+br bubble1", {31'b0, ifid_valid}, 32'd0);
        step();
        check_output("stall+br bubble2", {31'b0, ifid_valid}, 32'd0);
        step();
        check_output("stall+br ifid_valid", {31'b0, ifid_valid}, 32'd1);
        check_output("stall+br ifid_pc", {16'h0, ifid_pc}, 32'h100);
        check_output("stall+br ifid_instr", ifid_instr, 32'h100);

        // PC wrap at 16'hFFFF.
        branch_taken  = 1'b1;
        branch_target = 16'hFFFF;
        step();
        branch_taken = 1'b0;
        #1;
        check_output("wrap pc_next", {16'h0, pc_next}, 32'd0);
        step();
        step();
        check_output("wrap ifid_pc FFFF", {16'h0, ifid_pc}, 32'hFFFF);
        check_output("wrap ifid_instr FFFF", ifid_instr, 32'hFFFF);
        step();
        check_output("wrap ifid_pc 0", {16'h0, ifid_pc}, 32'd0);

        // HALT at address 7.
        halt_en = 1'b1;
        do_reset();
        reset = 1'b0;
        wait_for_ifid(16'd7);
        check_output("halt ifid_instr", ifid_instr, 32'hF000_0007);
        check_output("halt not yet", {31'b0, halted}, 32'd0);
        check_output("halt pc_next pre", {16'h0, pc_next}, 32'd10);
        step();
        check_output("halted set", {31'b0, halted}, 32'd1);
        check_output("halted ifid_valid", {31'b0, ifid_valid}, 32'd0);
        check_output("halted pc_next", {16'h0, pc_next}, 32'd10);
        branch_taken  = 1'b1;
        branch_target = 16'h0055;
        #1;
        check_output("halted branch pc_next", {16'h0, pc_next}, 32'd10);
        step();
        branch_taken = 1'b0;
        #1;
        check_output("halted sticky", {31'b0, halted}, 32'd1);
        check_output("halted pc frozen", {16'h0, pc_next}, 32'd10);
        reset = 1'b1;
        step();
        check_output("halt reset halted", {31'b0, halted}, 32'd0);
        check_output("halt reset ifid_valid", {31'b0, ifid_valid}, 32'd0);
        reset = 1'b0;
        #1;
        check_output("halt reset pc_next", {16'h0, pc_next}, 32'd1);

        // HALT in IF/ID flushed by a simultaneous branch.
        wait_for_ifid(16'd7);
        branch_taken  = 1'b1;
        branch_target = 16'h0020;
        #1;
        check_output("halt+br pc_next", {16'h0, pc_next}, 32'h20);
        step();
        branch_taken = 1'b0;
        #1;
        check_output("halt+br halted e1", {31'b0, halted}, 32'd0);
        check_output("halt+br bubble1", {31'b0, ifid_valid}, 32'd0);
        step();
        check_output("halt+br bubble2", {31'b0, ifid_valid}, 32'd0);
        step();
        check_output("halt+br ifid_pc", {16'h0, ifid_pc}, 32'h20);
        check_output("halt+br ifid_valid", {31'b0, ifid_valid}, 32'd1);
        check_output("halt+br halted e3", {31'b0, halted}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
